// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for one shared datapath resource behind an N:1 mux.
// Produces a one-hot grant plus a binary select for the mux. A grant is held
// until the resource pulses done or the owner drops its request.
// Optional feature: define ARB_TIMEOUT_EN to revoke grants that last HOLD_MAX
// cycles and pulse timeout_o when that happens.
module mux_rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     gnt_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             timeout_q, timeout_d;

  logic             release_norm, release_force, release_any;
  logic             win_valid;
  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] scan_idx;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
`endif

  // Release of the current owner: normal (done or request withdrawn) or forced by the hold limit
  always_comb begin
    release_norm  = (state_q == StGrant) && (done_i || !req_i[sel_q]);
`ifdef ARB_TIMEOUT_EN
    release_force = (state_q == StGrant) && !release_norm && (cnt_q == 8'(HOLD_MAX - 1));
`else
    release_force = 1'b0;
`endif
    release_any   = release_norm || release_force;
    // On release the owner becomes lowest priority for the re-arbitration in this same edge
    ptr_d         = release_any ? sel_q + SEL_W'(1) : ptr_q;
  end

  // Round-robin scan starting at ptr_d, wrapping modulo N (N is a power of two)
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_d;
    scan_idx  = ptr_d;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = ptr_d + SEL_W'(i);
      if (!win_valid && req_i[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state logic: arbitrate when idle or on release, otherwise hold the grant
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d        = StGrant;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          sel_d          = win_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d          = 8'd0;
`endif
        end
      end
      StGrant: begin
        if (release_any) begin
          timeout_d = release_force;
          if (win_valid) begin
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            sel_d          = win_idx;
`ifdef ARB_TIMEOUT_EN
            cnt_d          = 8'd0;
`endif
          end else begin
            // sel keeps pointing at the last owner while idle
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous reset so a grant drops immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign busy_o    = |gnt_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (N=4, HOLD_MAX=4).
// A behavioural model tracks owner/pointer/hold count; every falling edge the
// DUT outputs are compared against it, and directed literals pin the model.
module tb_mux_rr_arbiter;

  localparam int N        = 4;
  localparam int SEL_W    = 2;
  localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_to    = 0;

  mux_rr_arbiter #(
    .N        (N),
    .SEL_W    (SEL_W),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .sel_o     (sel),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: rules applied directly to owner/pointer integers
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_to    = 0;
      end else begin
        bit rel;
        bit frc;
        m_to = 0;
        if (m_owner >= 0) begin
          rel = done || !req[m_owner];
          frc = TO_EN && !rel && (m_cnt == HOLD_MAX - 1);
          if (rel || frc) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_to    = frc ? 1 : 0;
          end else begin
            m_cnt++;
          end
        end
        if (m_owner < 0) begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (m_owner < 0 && req[idx]) begin
              m_owner = idx;
              m_sel   = idx;
              m_cnt   = 0;
            end
          end
        end
      end
    end
  end

  // Compare DUT against the model away from the rising edge
  always @(negedge clk) begin
    int exp_gnt;
    exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
    check("model_gnt", 32'(gnt), 32'(exp_gnt));
    check("model_sel", 32'(sel), 32'(m_sel));
    check("model_busy", 32'(busy), 32'(m_owner >= 0));
    check("model_timeout", 32'(timeout), 32'(m_to));
  end

  // Directed stimulus with literal expectations
  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_sel", 32'(sel), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_timeout", 32'(timeout), 0);

    // Single requester, then done with request dropped: one release, ptr -> 3
    rst = 1'b0;
    req = 4'b0100;
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_sel", 32'(sel), 2);
    check("t1_busy", 32'(busy), 1);
    req  = 4'b0000;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("t1_rel_gnt", 32'(gnt), 0);
    check("t1_rel_busy", 32'(busy), 0);
    check("t1_sel_hold", 32'(sel), 2);
    check("t1_ptr", 32'(m_ptr), 3);

    // Move ptr to 0 via owner 3
    req = 4'b1000;
    @(negedge clk);
    check("t2_pre_gnt", 32'(gnt), 32'h8);
    req = 4'b0000;
    @(negedge clk);
    check("t2_pre_ptr", 32'(m_ptr), 0);

    // All requesting, done every second cycle: 0,1,2,3,0 with no gaps
    req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("t2_order_sel", 32'(sel), 32'(exp_order[k]));
      check("t2_order_gnt", 32'(gnt), 32'(1 << exp_order[k]));
      done = 1'b0;
      @(negedge clk);
      check("t2_hold_sel", 32'(sel), 32'(exp_order[k]));
      done = 1'b1;
      @(negedge clk);
    end

    // Wrap-around: owner 3 -> owner 0 -> owner 3
    req  = 4'b1000;
    done = 1'b1;
    @(negedge clk);
    check("t3_sel3", 32'(sel), 3);
    req = 4'b1001;
    @(negedge clk);
    check("t3_wrap_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    check("t3_back_gnt", 32'(gnt), 32'h8);

    // Owner 1 withdraws without done; pending requester 2 takes over same edge
    req  = 4'b0010;
    done = 1'b1;
    @(negedge clk);
    check("t4_own1", 32'(gnt), 32'h2);
    req  = 4'b0100;
    done = 1'b0;
    @(negedge clk);
    check("t4_handover", 32'(gnt), 32'h4);
    check("t4_ptr", 32'(m_ptr), 2);

    // Asynchronous reset mid-grant, then scan restarts at index 0
    req  = 4'b0010;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("t5_own1", 32'(gnt), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("t5_async_gnt", 32'(gnt), 0);
    check("t5_async_sel", 32'(sel), 0);
    check("t5_async_busy", 32'(busy), 0);
    req = 4'b1011;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_first_gnt", 32'(gnt), 32'h1);

    // Owner 0 never releases; hold limit decides what happens after 4 cycles
    repeat (3) @(negedge clk);
    check("t6_still_gnt", 32'(gnt), 32'h1);
    check("t6_no_to", 32'(timeout), 0);
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    check("t6_to_gnt", 32'(gnt), 32'h2);
    check("t6_to_pulse", 32'(timeout), 1);
`else
    check("t6_to_gnt", 32'(gnt), 32'h1);
    check("t6_to_pulse", 32'(timeout), 0);
`endif
    @(negedge clk);
    check("t6_to_end", 32'(timeout), 0);

    req = '0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
